sweep_sched: RTL and testbench

SWEEP_SCHED -- requirements
Module: sweep_sched

---
 rtl/sweep_sched.sv | 176 +++++++++++++++++
 tb/tb_sweep_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_sched.sv
// Learn-sweep scheduler: steps a DDS through N_POINTS frequencies, waits for settling,
// and gates FFT enable and spectrum capture on the last of FRAMES frames per point.
module sweep_sched #(
  parameter int unsigned N_POINTS   = 100,
  parameter int unsigned SETTLE_CYC = 50000,
  parameter int unsigned FRAMES     = 2
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       frame_done,
  output logic       learn_en,
  output logic       next_freq,
  output logic       fft_valid,
  output logic       capture_en,
  output logic [7:0] pt_idx,
  output logic       busy,
  output logic       done,
  output logic       learn_done
);

  localparam int unsigned CNT_W = 20;
  localparam int unsigned FC_W  = 4;
  localparam int unsigned PT_W  = 8;

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [FC_W-1:0]  LAST_FRAME  = FC_W'(FRAMES - 1);
  localparam logic [PT_W-1:0]  LAST_PT     = PT_W'(N_POINTS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    RUN    = 3'd2,
    STEP   = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [FC_W-1:0]   frame_inc;
  logic [PT_W-1:0]   pt_idx_q, pt_idx_d;
  logic              learn_en_q, learn_en_d;
  logic              next_freq_q, next_freq_d;
  logic              fft_valid_q, fft_valid_d;
  logic              capture_en_q, capture_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              learn_done_q, learn_done_d;

  // State and registered outputs
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      frame_cnt_q  <= '0;
      pt_idx_q     <= '0;
      learn_en_q   <= 1'b0;
      next_freq_q  <= 1'b0;
      fft_valid_q  <= 1'b0;
      capture_en_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      learn_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      pt_idx_q     <= pt_idx_d;
      learn_en_q   <= learn_en_d;
      next_freq_q  <= next_freq_d;
      fft_valid_q  <= fft_valid_d;
      capture_en_q <= capture_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      learn_done_q <= learn_done_d;
    end
  end

  assign frame_inc = FC_W'(frame_cnt_q + FC_W'(1));

  // Next state and next output values
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_cnt_d  = frame_cnt_q;
    pt_idx_d     = pt_idx_q;
    learn_en_d   = learn_en_q;
    next_freq_d  = 1'b0;
    fft_valid_d  = fft_valid_q;
    capture_en_d = capture_en_q;
    done_d       = 1'b0;
    learn_done_d = learn_done_q;

    if (state_q != IDLE && abort) begin
      // Abort drops everything except the sticky completion flag
      state_d      = IDLE;
      cnt_d        = '0;
      frame_cnt_d  = '0;
      pt_idx_d     = '0;
      learn_en_d   = 1'b0;
      fft_valid_d  = 1'b0;
      capture_en_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d      = SETTLE;
            cnt_d        = SETTLE_LOAD;
            frame_cnt_d  = '0;
            pt_idx_d     = '0;
            learn_en_d   = 1'b1;
            fft_valid_d  = 1'b0;
            capture_en_d = 1'b0;
            learn_done_d = 1'b0;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_d      = RUN;
            frame_cnt_d  = '0;
            fft_valid_d  = 1'b1;
            capture_en_d = (LAST_FRAME == '0);
          end else begin
            cnt_d = CNT_W'(cnt_q - CNT_W'(1));
          end
        end
        RUN: begin
          if (frame_done) begin
            if (frame_cnt_q == LAST_FRAME) begin
              frame_cnt_d  = '0;
              fft_valid_d  = 1'b0;
              capture_en_d = 1'b0;
              if (pt_idx_q == LAST_PT) begin
                state_d      = FINISH;
                done_d       = 1'b1;
                learn_done_d = 1'b1;
                learn_en_d   = 1'b0;
              end else begin
                state_d     = STEP;
                next_freq_d = 1'b1;
                pt_idx_d    = PT_W'(pt_idx_q + PT_W'(1));
              end
            end else begin
              frame_cnt_d  = frame_inc;
              capture_en_d = (frame_inc == LAST_FRAME);
            end
          end
        end
        STEP: begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
        FINISH: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign learn_en   = learn_en_q;
  assign next_freq  = next_freq_q;
  assign fft_valid  = fft_valid_q;
  assign capture_en = capture_en_q;
  assign pt_idx     = pt_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign learn_done = learn_done_q;

endmodule

// File: tb/tb_sweep_sched.sv
// Bench for sweep_sched: directed table, corner sequences and random stimulus
// against a phase-level reference model, on two parameterisations sharing inputs.
module tb_sweep_sched;

  logic clk_50m = 1'b0;
  always #10 clk_50m = ~clk_50m;

  logic rst_n, start, abort, frame_done;
  logic       a_le, a_nf, a_fv, a_cap, a_busy, a_done, a_ld;
  logic [7:0] a_pt;
  logic       b_le, b_nf, b_fv, b_cap, b_busy, b_done, b_ld;
  logic [7:0] b_pt;

  sweep_sched #(.N_POINTS(3), .SETTLE_CYC(4), .FRAMES(2)) dut_a (
    .clk_50m(clk_50m), .rst_n(rst_n), .start(start), .abort(abort),
    .frame_done(frame_done), .learn_en(a_le), .next_freq(a_nf),
    .fft_valid(a_fv), .capture_en(a_cap), .pt_idx(a_pt), .busy(a_busy),
    .done(a_done), .learn_done(a_ld));

  sweep_sched #(.N_POINTS(1), .SETTLE_CYC(3), .FRAMES(1)) dut_b (
    .clk_50m(clk_50m), .rst_n(rst_n), .start(start), .abort(abort),
    .frame_done(frame_done), .learn_en(b_le), .next_freq(b_nf),
    .fft_valid(b_fv), .capture_en(b_cap), .pt_idx(b_pt), .busy(b_busy),
    .done(b_done), .learn_done(b_ld));

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: phase of the sweep plus counters, outputs derived from phase
  localparam int P_IDLE = 0, P_SETTLE = 1, P_RUN = 2, P_STEP = 3, P_FIN = 4;
  int p_n[2] = '{3, 1};
  int p_s[2] = '{4, 3};
  int p_f[2] = '{2, 1};
  int m_phase[2], m_left[2], m_frames[2], m_pt[2];
  bit m_ld[2];

  function automatic logic [14:0] mk(bit bz, bit le, bit fv, bit cap, bit nf,
                                     bit dn, bit ld, int pt);
    return {bz, le, fv, cap, nf, dn, ld, 8'(pt)};
  endfunction

  function automatic logic [14:0] exp_out(int i);
    return mk(m_phase[i] != P_IDLE,
              m_phase[i] == P_SETTLE || m_phase[i] == P_RUN || m_phase[i] == P_STEP,
              m_phase[i] == P_RUN,
              m_phase[i] == P_RUN && m_frames[i] == p_f[i] - 1,
              m_phase[i] == P_STEP,
              m_phase[i] == P_FIN,
              m_ld[i], m_pt[i]);
  endfunction

  function automatic logic [14:0] act_out(int i);
    if (i == 0) return {a_busy, a_le, a_fv, a_cap, a_nf, a_done, a_ld, a_pt};
    return {b_busy, b_le, b_fv, b_cap, b_nf, b_done, b_ld, b_pt};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = P_IDLE; m_left[i] = 0; m_frames[i] = 0; m_pt[i] = 0; m_ld[i] = 0;
    end
  endtask

  task automatic model_clock();
    for (int i = 0; i < 2; i++) begin
      if (m_phase[i] != P_IDLE && abort) begin
        m_phase[i] = P_IDLE; m_pt[i] = 0; m_frames[i] = 0;
      end else begin
        case (m_phase[i])
          P_IDLE: if (start && !abort) begin
            m_phase[i] = P_SETTLE; m_left[i] = p_s[i]; m_pt[i] = 0; m_ld[i] = 0;
          end
          P_SETTLE: begin
            m_left[i]--;
            if (m_left[i] == 0) begin m_phase[i] = P_RUN; m_frames[i] = 0; end
          end
          P_RUN: if (frame_done) begin
            if (m_frames[i] == p_f[i] - 1) begin
              if (m_pt[i] == p_n[i] - 1) begin m_phase[i] = P_FIN; m_ld[i] = 1; end
              else begin m_phase[i] = P_STEP; m_pt[i]++; end
            end else m_frames[i]++;
          end
          P_STEP: begin m_phase[i] = P_SETTLE; m_left[i] = p_s[i]; end
          default: m_phase[i] = P_IDLE;
        endcase
      end
    end
  endtask

  task automatic check(string name, logic [14:0] act, logic [14:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (busy,le,fv,cap,nf,done,ld,pt)", name, act, exp);
    end
  endtask

  task automatic check_bit(string name, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic cyc(bit s, bit a, bit f, string name);
    @(negedge clk_50m);
    start = s; abort = a; frame_done = f;
    @(posedge clk_50m);
    model_clock();
    #1;
    check({name, "/a"}, act_out(0), exp_out(0));
    check({name, "/b"}, act_out(1), exp_out(1));
  endtask

  task automatic do_reset();
    @(negedge clk_50m);
    rst_n = 1'b0; start = 0; abort = 0; frame_done = 0;
    model_reset();
    @(negedge clk_50m);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          st;
    bit          ab;
    bit          fd;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[18];
  int nf_cnt, dn_cnt;
  bit got;

  initial begin
    rst_n = 1'b0; start = 0; abort = 0; frame_done = 0;
    model_reset();
    #25;
    check("reset/a", act_out(0), 15'd0);
    check("reset/b", act_out(1), 15'd0);
    @(negedge clk_50m);
    rst_n = 1'b1;

    // Directed table for the 3-point, settle-4, 2-frame instance
    tbl[0]  = '{1, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{0, 0, 1, mk(1, 1, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{0, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{0, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{0, 0, 0, mk(1, 1, 1, 0, 0, 0, 0, 0)};
    tbl[5]  = '{1, 0, 0, mk(1, 1, 1, 0, 0, 0, 0, 0)};
    tbl[6]  = '{0, 0, 1, mk(1, 1, 1, 1, 0, 0, 0, 0)};
    tbl[7]  = '{0, 0, 0, mk(1, 1, 1, 1, 0, 0, 0, 0)};
    tbl[8]  = '{0, 0, 1, mk(1, 1, 0, 0, 1, 0, 0, 1)};
    tbl[9]  = '{0, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 1)};
    tbl[10] = '{0, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 1)};
    tbl[11] = '{0, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 1)};
    tbl[12] = '{0, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 1)};
    tbl[13] = '{0, 0, 0, mk(1, 1, 1, 0, 0, 0, 0, 1)};
    tbl[14] = '{0, 0, 1, mk(1, 1, 1, 1, 0, 0, 0, 1)};
    tbl[15] = '{0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[16] = '{1, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[17] = '{1, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0)};
    for (int k = 0; k < 18; k++) begin
      cyc(tbl[k].st, tbl[k].ab, tbl[k].fd, $sformatf("tbl%0d_model", k));
      check($sformatf("tbl%0d", k), act_out(0), tbl[k].exp);
    end

    // Full sweep on the 3-point instance, frames delivered as fast as possible
    do_reset();
    cyc(1, 0, 0, "sweep_start");
    nf_cnt = 0; dn_cnt = 0; got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      cyc(0, 0, a_fv, "sweep");
      if (a_nf) nf_cnt++;
      if (a_done) begin dn_cnt++; got = 1; end
    end
    check_bit("sweep_done_seen", got, 1'b1);
    check_bit("sweep_nf_count", nf_cnt == 2, 1'b1);
    check_bit("sweep_done_count", dn_cnt == 1, 1'b1);
    check_bit("sweep_pt_last", a_pt == 8'd2, 1'b1);
    cyc(0, 0, 0, "sweep_after");
    check_bit("sweep_learn_done", a_ld, 1'b1);
    check_bit("sweep_idle", a_busy, 1'b0);

    // Single point, single frame: done right after the frame, no step
    do_reset();
    cyc(1, 0, 0, "one_start");
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (b_fv) got = 1;
      else cyc(0, 0, 0, "one_settle");
    end
    check_bit("one_run_reached", got, 1'b1);
    check_bit("one_capture", b_cap, 1'b1);
    cyc(0, 0, 1, "one_frame");
    check_bit("one_done", b_done, 1'b1);
    check_bit("one_no_nf", b_nf, 1'b0);
    check_bit("one_learn_done", b_ld, 1'b1);

    // Asynchronous reset while settling
    do_reset();
    cyc(1, 0, 0, "ar_start");
    cyc(0, 0, 0, "ar_settle");
    @(negedge clk_50m);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst/a", act_out(0), 15'd0);
    check("async_rst/b", act_out(1), 15'd0);
    @(negedge clk_50m);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) cyc(0, 0, k[0], "ar_hold");

    // Random stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(7) == 0, $urandom_range(59) == 0,
          $urandom_range(2) == 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
